// File: rtl/clock_group_reset_sequencer.sv
// Releases the per-group resets one at a time after a common hold, and re-resets masked groups on request.
// Optional build macro CLKGRP_SEQ_STATUS_EN adds the io_seq_count completed-sequence counter.
module clock_group_reset_sequencer #(
    parameter int NUM_GROUPS  = 7,
    parameter int HOLD_CYCLES = 16,
    parameter int STEP_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_req_valid,
    output logic                  io_req_ready,
    input  logic [NUM_GROUPS-1:0] io_req_bits_mask,
    output logic [NUM_GROUPS-1:0] io_group_reset,
    output logic                  io_busy,
    output logic                  io_all_released
`ifdef CLKGRP_SEQ_STATUS_EN
   ,output logic [7:0]            io_seq_count
`endif
);

    localparam int IDX_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

    typedef enum logic [1:0] {HOLD, STEP, IDLE} state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [NUM_GROUPS-1:0] sel;
    logic [NUM_GROUPS-1:0] groupRst;
    logic [IDX_W-1:0]      idx;
    logic                  armed;

    logic [IDX_W-1:0]      relIdx;
    logic                  termCnt;
    logic                  moreAfter;
    logic                  seqDone;

    function automatic logic [IDX_W-1:0] lowestBit(input logic [NUM_GROUPS-1:0] v);
        lowestBit = '0;
        for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
            if (v[i]) lowestBit = IDX_W'(i);
        end
    endfunction

    function automatic logic [NUM_GROUPS-1:0] bitsAbove(input logic [NUM_GROUPS-1:0] v,
                                                        input logic [IDX_W-1:0]      pos);
        bitsAbove = '0;
        for (int i = 0; i < NUM_GROUPS; i++) begin
            bitsAbove[i] = v[i] && (i > int'(pos));
        end
    endfunction

    // Group released at the next terminal count, and whether any selected group remains after it.
    always_comb begin
        relIdx    = (state == HOLD) ? lowestBit(sel) : lowestBit(bitsAbove(sel, idx));
        moreAfter = |bitsAbove(sel, relIdx);
        termCnt   = 1'b0;
        case (state)
            HOLD:    termCnt = armed && (cnt == CNT_W'(HOLD_CYCLES - 1));
            STEP:    termCnt = (cnt == CNT_W'(STEP_CYCLES - 1));
            default: termCnt = 1'b0;
        endcase
        seqDone = termCnt && !moreAfter;
    end

    // The first edge after reset release only arms the counter, so power-on releases
    // land on the same t+HOLD+k*STEP grid as a run-time request accepted at edge t.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= HOLD;
            cnt      <= '0;
            sel      <= '1;
            idx      <= '0;
            groupRst <= '1;
            armed    <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                HOLD, STEP: begin
                    if (termCnt) begin
                        cnt              <= '0;
                        idx              <= relIdx;
                        groupRst[relIdx] <= 1'b0;
                        state            <= seqDone ? IDLE : STEP;
                    end else if (state == STEP || armed) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (io_req_valid && (|io_req_bits_mask)) begin
                        sel      <= io_req_bits_mask;
                        groupRst <= groupRst | io_req_bits_mask;
                        cnt      <= '0;
                        state    <= HOLD;
                    end
                end
                default: state <= HOLD;
            endcase
        end
    end

    assign io_group_reset  = groupRst;
    assign io_busy         = (state != IDLE);
    assign io_req_ready    = (state == IDLE);
    assign io_all_released = ~|groupRst;

`ifdef CLKGRP_SEQ_STATUS_EN
    logic [7:0] seqCount;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seqCount <= '0;
        end else if (seqDone && (seqCount != 8'hFF)) begin
            seqCount <= seqCount + 8'd1;
        end
    end

    assign io_seq_count = seqCount;
`endif

endmodule

// File: doc/clock_group_reset_sequencer.md
Name: clock_group_reset_sequencer

Overview:
Sequences reset release across the subsystem clock groups: implicit, sbus_0, sbus_1, pbus, fbus, mbus and cbus.
- Out of global reset, it holds every group in reset, then releases the groups one at a time in ascending index order with fixed spacing.
- At run time it accepts masked re-reset requests over a valid/ready handshake.
- It sits beside the clock group aggregator; its per-group reset outputs replace the raw member resets fed to each bus domain.

Parameters:
- NUM_GROUPS, 7, number of clock groups. Index 0 = implicit, 1 = sbus_0, 2 = sbus_1, 3 = pbus, 4 = fbus, 5 = mbus, 6 = cbus.
- HOLD_CYCLES, 16, cycles all selected groups stay in reset before the first release (must be ≥1).
- STEP_CYCLES, 8, cycles between consecutive group releases (must be ≥1).
- CNT_W, 8, counter width; must hold max(HOLD_CYCLES, STEP_CYCLES).

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- io_req_valid  in  1  re-reset request valid.
- io_req_ready  out  1  request can be accepted.
- io_req_bits_mask  in  NUM_GROUPS  groups to re-reset (bit i = group i).
- io_group_reset  out  NUM_GROUPS  per-group reset, active-high.
- io_busy  out  1  sequence in progress.
- io_all_released  out  1  every group_reset bit is 0.

Behaviour:
- Reset values while reset=1, asynchronously:
  - group_reset = all 1s; busy = 1; req_ready = 0; all_released = 0.
  - FSM = HOLD; cnt = 0; sel = all 1s; idx = 0.
- Cycle numbering: cycle 0 is the first rising edge after reset deasserts.
- FSM states: HOLD, STEP, IDLE.
- HOLD:
  - cnt increments each cycle.
  - When cnt == HOLD_CYCLES-1: cnt ← 0, idx ← lowest set bit of sel, clear group_reset[idx], go to STEP.
- STEP:
  - cnt increments each cycle.
  - When cnt == STEP_CYCLES-1: cnt ← 0, advance idx to the next set bit of sel above idx, clear group_reset for that bit.
  - When no set bit remains above idx: go to IDLE, with no extra cycle.
  - Only bits selected by sel are ever modified.
- IDLE:
  - busy = 0; req_ready = 1.
  - On valid & ready with mask ≠ 0: sel ← mask, group_reset ← group_reset | mask, cnt ← 0, go to HOLD.
  - Unselected groups are untouched.
  - mask == 0: handshake completes, no state change, no output change.
- io_req_ready is 1 only in IDLE. A request presented while busy stalls until IDLE; there is no queueing.
- Release timing from a HOLD entry at cycle t: group at the k-th set bit of sel deasserts at cycle t + HOLD_CYCLES + k·STEP_CYCLES (k from 0). The deassert is visible on the output after that edge.
- Single-group sel: the release occurs on leaving HOLD, then go to IDLE directly.
- all_released = ~|group_reset, combinational from registered group_reset.
- busy = (state ≠ IDLE).
- All outputs are registered or derived from registered state.
- Reset asserted mid-sequence: immediate return to all-asserted, and the full power-on sequence restarts.
- Counter never wraps: it is cleared at each terminal count.

Optional Feature:
- Macro: CLKGRP_SEQ_STATUS_EN.
- With the macro: adds output io_seq_count [7:0].
  - Increments by 1 on each STEP/HOLD→IDLE transition (completed sequence).
  - Saturates at 255; reset value 0.
  - The mask==0 handshake does not count.
- Without the macro: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Power-on, defaults:
  - group_reset = 7'h7F through cycle 15.
  - Bit0 clears after cycle 16, then bit1@24, bit2@32, bit3@40, bit4@48, bit5@56, bit6@64.
  - all_released = 1 and req_ready = 1 after cycle 64.
- IDLE, mask = 7'b0101000 accepted at cycle T:
  - group_reset = 7'h28 from T+1.
  - Bit3 clears at T+16, bit5 at T+24; other bits stay 0 throughout.
- Request with mask = 7'h7F while busy: req_ready = 0, and the request is held until IDLE, then accepted on the first IDLE cycle.
- mask = 0 in IDLE: handshake completes in 1 cycle; group_reset, busy and (if enabled) seq_count are unchanged.
- Assert reset at cycle 40 of power-on (bits 0–3 released): all bits return to 1 asynchronously; after deassert the power-on timing repeats exactly.
- CLKGRP_SEQ_STATUS_EN: after power-on, seq_count = 1; after 300 back-to-back single-bit requests, seq_count = 255.
